// File: rtl/sram_1rw1r_ctrl_if.sv
// Port bundle for sram_1rw1r_ctrl: read/write port 0, read-only port 1, status strobes.
interface sram_1rw1r_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) ();
  logic                  init_busy;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  collision;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  init_busy, dout0, dout0_valid, dout1, dout1_valid, collision
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output init_busy, dout0, dout0_valid, dout1, dout1_valid, collision
  );
endinterface

// File: rtl/sram_1rw1r_ctrl.sv
// 1RW1R synchronous RAM wrapper: post-reset clearing, read-valid strobes,
// write-first forwarding from port 0 writes to same-address port 1 reads.
module sram_1rw1r_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_WMASKS = 4,
  parameter bit                    OUT_REG    = 1'b0,
  parameter bit                    INIT_EN    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic              clk,
  input logic              rstb,
  sram_1rw1r_ctrl_if.slave bus
);
  localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt_reg, init_cnt_next;
  logic                  ready;
  logic [NUM_WMASKS-1:0] wr_lanes;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd0_req, rd1_req, wr_req;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= INIT_EN ? ST_INIT : ST_READY;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  // The single write port is shared between the clearing sweep and port 0.
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    ready         = 1'b0;
    wr_lanes      = '0;
    wr_addr       = bus.addr0;
    wr_data       = bus.din0;
    case (state_reg)
      ST_INIT: begin
        wr_lanes      = '1;
        wr_addr       = init_cnt_reg;
        wr_data       = INIT_VALUE;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == '1) begin
          state_next = ST_READY;
        end
      end
      default: begin
        ready = 1'b1;
        if (!bus.csb0 && !bus.web0) begin
          wr_lanes = bus.wmask0;
        end
      end
    endcase
  end

  assign rd0_req = ready && !bus.csb0 && bus.web0;
  assign wr_req  = ready && !bus.csb0 && !bus.web0;
  assign rd1_req = ready && !bus.csb1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata0_reg, rdata1_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  // Reads return the pre-write word; same-edge forwarding is merged one stage later.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wr_lanes[i]) begin
        mem[wr_addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
    rdata0_reg   <= mem[bus.addr0];
    rdata1_reg   <= mem[bus.addr1];
    fwd_data_reg <= bus.din0;
  end

  logic                  rd0_s1_reg, rd1_s1_reg;
  logic [NUM_WMASKS-1:0] fwd_mask_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd0_s1_reg   <= 1'b0;
      rd1_s1_reg   <= 1'b0;
      fwd_mask_reg <= '0;
    end else begin
      rd0_s1_reg   <= rd0_req;
      rd1_s1_reg   <= rd1_req;
      fwd_mask_reg <= (wr_req && rd1_req && (bus.addr0 == bus.addr1)) ? bus.wmask0 : '0;
    end
  end

  logic [DATA_WIDTH-1:0] rd1_merged;

  generate
    for (genvar gi = 0; gi < NUM_WMASKS; gi++) begin : g_fwd_lane
      assign rd1_merged[gi*LANE_WIDTH +: LANE_WIDTH] = fwd_mask_reg[gi]
          ? fwd_data_reg[gi*LANE_WIDTH +: LANE_WIDTH]
          : rdata1_reg[gi*LANE_WIDTH +: LANE_WIDTH];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] dout0_reg, dout1_reg;
  logic                  valid0_reg, valid1_reg, collision_reg;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout0_reg     <= '0;
      dout1_reg     <= '0;
      valid0_reg    <= 1'b0;
      valid1_reg    <= 1'b0;
      collision_reg <= 1'b0;
    end else begin
      valid0_reg    <= rd0_s1_reg;
      valid1_reg    <= rd1_s1_reg;
      collision_reg <= |fwd_mask_reg;
      if (rd0_s1_reg) dout0_reg <= rdata0_reg;
      if (rd1_s1_reg) dout1_reg <= rd1_merged;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] dout0_out_reg, dout1_out_reg;
      logic                  valid0_out_reg, valid1_out_reg, collision_out_reg;

      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          dout0_out_reg     <= '0;
          dout1_out_reg     <= '0;
          valid0_out_reg    <= 1'b0;
          valid1_out_reg    <= 1'b0;
          collision_out_reg <= 1'b0;
        end else begin
          dout0_out_reg     <= dout0_reg;
          dout1_out_reg     <= dout1_reg;
          valid0_out_reg    <= valid0_reg;
          valid1_out_reg    <= valid1_reg;
          collision_out_reg <= collision_reg;
        end
      end

      assign bus.dout0       = dout0_out_reg;
      assign bus.dout1       = dout1_out_reg;
      assign bus.dout0_valid = valid0_out_reg;
      assign bus.dout1_valid = valid1_out_reg;
      assign bus.collision   = collision_out_reg;
    end else begin : g_no_out_reg
      assign bus.dout0       = dout0_reg;
      assign bus.dout1       = dout1_reg;
      assign bus.dout0_valid = valid0_reg;
      assign bus.dout1_valid = valid1_reg;
      assign bus.collision   = collision_reg;
    end
  endgenerate

  assign bus.init_busy = (state_reg == ST_INIT);
endmodule

// File: tb/tb_sram_1rw1r_ctrl.sv
// Bench for sram_1rw1r_ctrl: three configurations side by side, checked every cycle
// against an array/queue model plus literal expectations from the test plan.
module tb_sram_1rw1r_ctrl;
  logic clk = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-DUT stimulus (0: 32x16 OUT_REG=0, 1: 32x16 OUT_REG=1, 2: 64x1024 no clearing)
  logic        csb0_t [3];
  logic        web0_t [3];
  logic        csb1_t [3];
  logic [7:0]  wmask0_t [3];
  logic [9:0]  addr0_t [3];
  logic [9:0]  addr1_t [3];
  logic [63:0] din0_t [3];
  logic [63:0] dout0_o [3];
  logic [63:0] dout1_o [3];
  logic        v0_o [3];
  logic        v1_o [3];
  logic        coll_o [3];
  logic        busy_o [3];

  sram_1rw1r_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4)) bus_a ();
  sram_1rw1r_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4)) bus_b ();
  sram_1rw1r_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .NUM_WMASKS(8)) bus_c ();

  sram_1rw1r_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4), .OUT_REG(1'b0),
                    .INIT_EN(1'b1), .INIT_VALUE(32'hDEADBEEF))
    dut_a (.clk(clk), .rstb(rstb), .bus(bus_a.slave));
  sram_1rw1r_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_WMASKS(4), .OUT_REG(1'b1),
                    .INIT_EN(1'b1), .INIT_VALUE(32'h0))
    dut_b (.clk(clk), .rstb(rstb), .bus(bus_b.slave));
  sram_1rw1r_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .NUM_WMASKS(8), .OUT_REG(1'b0),
                    .INIT_EN(1'b0), .INIT_VALUE(64'h0))
    dut_c (.clk(clk), .rstb(rstb), .bus(bus_c.slave));

  assign bus_a.csb0 = csb0_t[0];  assign bus_a.web0 = web0_t[0];
  assign bus_a.wmask0 = wmask0_t[0][3:0];
  assign bus_a.addr0 = addr0_t[0][3:0];  assign bus_a.din0 = din0_t[0][31:0];
  assign bus_a.csb1 = csb1_t[0];  assign bus_a.addr1 = addr1_t[0][3:0];
  assign dout0_o[0] = {32'h0, bus_a.dout0};  assign dout1_o[0] = {32'h0, bus_a.dout1};
  assign v0_o[0] = bus_a.dout0_valid;  assign v1_o[0] = bus_a.dout1_valid;
  assign coll_o[0] = bus_a.collision;  assign busy_o[0] = bus_a.init_busy;

  assign bus_b.csb0 = csb0_t[1];  assign bus_b.web0 = web0_t[1];
  assign bus_b.wmask0 = wmask0_t[1][3:0];
  assign bus_b.addr0 = addr0_t[1][3:0];  assign bus_b.din0 = din0_t[1][31:0];
  assign bus_b.csb1 = csb1_t[1];  assign bus_b.addr1 = addr1_t[1][3:0];
  assign dout0_o[1] = {32'h0, bus_b.dout0};  assign dout1_o[1] = {32'h0, bus_b.dout1};
  assign v0_o[1] = bus_b.dout0_valid;  assign v1_o[1] = bus_b.dout1_valid;
  assign coll_o[1] = bus_b.collision;  assign busy_o[1] = bus_b.init_busy;

  assign bus_c.csb0 = csb0_t[2];  assign bus_c.web0 = web0_t[2];
  assign bus_c.wmask0 = wmask0_t[2];
  assign bus_c.addr0 = addr0_t[2];  assign bus_c.din0 = din0_t[2];
  assign bus_c.csb1 = csb1_t[2];  assign bus_c.addr1 = addr1_t[2];
  assign dout0_o[2] = bus_c.dout0;  assign dout1_o[2] = bus_c.dout1;
  assign v0_o[2] = bus_c.dout0_valid;  assign v1_o[2] = bus_c.dout1_valid;
  assign coll_o[2] = bus_c.collision;  assign busy_o[2] = bus_c.init_busy;

  function automatic int lat_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction
  function automatic int clr_of(input int d);
    return (d == 2) ? 0 : 16;
  endfunction
  function automatic logic [63:0] ival_of(input int d);
    return (d == 0) ? 64'hDEADBEEF : 64'h0;
  endfunction
  function automatic logic [9:0] amask_of(input int d);
    return (d == 2) ? 10'h3FF : 10'h00F;
  endfunction
  function automatic logic [7:0] lmask_of(input int d);
    return (d == 2) ? 8'hFF : 8'h0F;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h, want %h", name, d, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        v0;
    logic [63:0] d0;
    logic        v1;
    logic [63:0] d1;
    logic        c;
  } slot_t;

  logic [63:0] mm [3][1024];
  int          busy_cnt [3];
  slot_t       pipe [3][2];
  logic        m_v0 [3], m_v1 [3], m_c [3];
  logic [63:0] m_d0 [3], m_d1 [3];
  slot_t       m_nw;
  logic [9:0]  m_a0, m_a1;
  logic [7:0]  m_wm;

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int d = 0; d < 3; d++) begin
        busy_cnt[d] = clr_of(d);
        pipe[d][0] = '0;
        pipe[d][1] = '0;
        m_v0[d] = 1'b0; m_v1[d] = 1'b0; m_c[d] = 1'b0;
        m_d0[d] = 64'h0; m_d1[d] = 64'h0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        // Output what was scheduled for this edge, then advance the delay line.
        m_v0[d] = pipe[d][0].v0;
        m_v1[d] = pipe[d][0].v1;
        m_c[d]  = pipe[d][0].c;
        if (pipe[d][0].v0) m_d0[d] = pipe[d][0].d0;
        if (pipe[d][0].v1) m_d1[d] = pipe[d][0].d1;
        pipe[d][0] = pipe[d][1];
        pipe[d][1] = '0;
        if (busy_cnt[d] > 0) begin
          mm[d][(int'(amask_of(d)) + 1) - busy_cnt[d]] = ival_of(d);
          busy_cnt[d]--;
        end else begin
          m_nw = '0;
          m_a0 = addr0_t[d] & amask_of(d);
          m_a1 = addr1_t[d] & amask_of(d);
          m_wm = wmask0_t[d] & lmask_of(d);
          if (!csb0_t[d] && web0_t[d]) begin
            m_nw.v0 = 1'b1;
            m_nw.d0 = mm[d][m_a0];
          end
          if (!csb1_t[d]) begin
            m_nw.v1 = 1'b1;
            m_nw.d1 = mm[d][m_a1];
          end
          if (!csb0_t[d] && !web0_t[d]) begin
            for (int b = 0; b < 8; b++)
              if (m_wm[b]) mm[d][m_a0][8*b +: 8] = din0_t[d][8*b +: 8];
            if (!csb1_t[d] && m_a0 == m_a1 && m_wm != 8'h0) begin
              m_nw.c  = 1'b1;
              m_nw.d1 = mm[d][m_a0];
            end
          end
          pipe[d][lat_of(d)-1] = m_nw;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rstb) begin
      for (int d = 0; d < 3; d++) begin
        chk("init_busy", d, 64'(busy_o[d]), 64'(busy_cnt[d] > 0));
        chk("dout0_valid", d, 64'(v0_o[d]), 64'(m_v0[d]));
        chk("dout1_valid", d, 64'(v1_o[d]), 64'(m_v1[d]));
        chk("collision", d, 64'(coll_o[d]), 64'(m_c[d]));
        chk("dout0", d, dout0_o[d], m_d0[d]);
        chk("dout1", d, dout1_o[d], m_d1[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      csb0_t[d] = 1'b1; web0_t[d] = 1'b1; csb1_t[d] = 1'b1;
      wmask0_t[d] = 8'h0; addr0_t[d] = 10'h0; addr1_t[d] = 10'h0; din0_t[d] = 64'h0;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    idle_all();
  endtask

  task automatic set_wr(input int d, input int a, input logic [63:0] data, input logic [7:0] m);
    csb0_t[d] = 1'b0; web0_t[d] = 1'b0; addr0_t[d] = 10'(a); din0_t[d] = data; wmask0_t[d] = m;
  endtask

  task automatic set_rd0(input int d, input int a);
    csb0_t[d] = 1'b0; web0_t[d] = 1'b1; addr0_t[d] = 10'(a);
  endtask

  task automatic set_rd1(input int d, input int a);
    csb1_t[d] = 1'b0; addr1_t[d] = 10'(a);
  endtask

  int cnt;

  initial begin
    idle_all();
    #2 rstb = 1'b0;
    @(negedge clk);
    chk("reset busy", 0, 64'(busy_o[0]), 64'h1);
    chk("reset busy", 2, 64'(busy_o[2]), 64'h0);
    chk("reset dout1", 0, dout1_o[0], 64'h0);
    #2 rstb = 1'b1;
    #1;
    chk("busy after release", 2, 64'(busy_o[2]), 64'h0);
    cnt = 0;
    while (busy_o[0] && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("init cycles", 0, 64'(cnt), 64'd16);
    idle_all();

    // Cleared word readback
    set_rd1(0, 9); cyc(); cyc();
    chk("cleared read", 0, dout1_o[0], 64'hDEADBEEF);
    chk("cleared valid", 0, 64'(v1_o[0]), 64'h1);

    // Masked writes, 32-bit and 64-bit lanes
    set_wr(0, 5, 64'h11223344, 8'hF); set_wr(2, 0, 64'h0102030405060708, 8'hFF); cyc();
    set_wr(0, 5, 64'hAABBCCDD, 8'h5); set_wr(2, 0, 64'hA1A2A3A4A5A6A7A8, 8'hA5); cyc();
    set_wr(2, 1023, 64'hFFEEDDCCBBAA9988, 8'hFF); cyc();
    set_wr(0, 5, 64'hFFFFFFFF, 8'h0); set_wr(2, 1023, 64'h0, 8'h0F); cyc();
    set_rd0(0, 5); set_rd0(2, 0); set_rd1(2, 1023); cyc(); cyc();
    chk("masked read", 0, dout0_o[0], 64'h11BB33DD);
    chk("masked valid", 0, 64'(v0_o[0]), 64'h1);
    chk("wide addr0", 2, dout0_o[2], 64'hA102A30405A607A8);
    chk("wide addr1023", 2, dout1_o[2], 64'hFFEEDDCC00000000);
    cyc();
    chk("valid one cycle", 0, 64'(v0_o[0]), 64'h0);

    // Same-address forwarding and non-colliding cases
    set_wr(0, 3, 64'h0, 8'hF); cyc();
    set_wr(0, 3, 64'hCAFEF00D, 8'h3); set_rd1(0, 3); cyc(); cyc();
    chk("fwd dout1", 0, dout1_o[0], 64'h0000F00D);
    chk("fwd collision", 0, 64'(coll_o[0]), 64'h1);
    chk("fwd valid", 0, 64'(v1_o[0]), 64'h1);
    set_wr(0, 3, 64'hCAFEF00D, 8'h3); set_rd1(0, 4); cyc(); cyc();
    chk("no-coll collision", 0, 64'(coll_o[0]), 64'h0);
    chk("no-coll dout1", 0, dout1_o[0], 64'hDEADBEEF);
    set_wr(0, 4, 64'h0, 8'h0); set_rd1(0, 4); cyc(); cyc();
    chk("mask0 collision", 0, 64'(coll_o[0]), 64'h0);

    // OUT_REG=1 streaming on both ports
    for (int i = 0; i < 16; i++) begin
      set_wr(1, i, {32'h0, 8'(i), 8'hA5, 8'(i), 8'h5A}, 8'hF);
      cyc();
    end
    for (int k = 0; k < 6; k++) begin
      set_rd0(1, k); set_rd1(1, k + 8);
      cyc();
      if (k == 0) chk("lat2 not yet", 1, 64'(v0_o[1]), 64'h0);
      if (k == 2) begin
        chk("lat2 dout0", 1, dout0_o[1], 64'h00A5005A);
        chk("lat2 dout1", 1, dout1_o[1], 64'h08A5085A);
      end
    end
    cyc(); cyc(); cyc();
    chk("hold dout0", 1, dout0_o[1], 64'h05A5055A);
    chk("hold dout1", 1, dout1_o[1], 64'h0DA50D5A);
    chk("hold valid", 1, 64'(v0_o[1]), 64'h0);

    // Reset with reads in flight and a committed write on the wide instance
    set_rd0(1, 0); set_wr(2, 1, 64'h5555AAAA5555AAAA, 8'hFF); cyc();
    #2 rstb = 1'b0;
    #1;
    chk("inflight valid", 1, 64'(v0_o[1]), 64'h0);
    chk("inflight dout0", 1, dout0_o[1], 64'h0);
    @(negedge clk);
    #2 rstb = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_wr(0, 2, 64'h12345678, 8'hF); set_rd1(0, 2); set_rd0(1, 0); set_rd1(1, 1);
      cyc();
    end
    #2 rstb = 1'b0;
    @(negedge clk);
    #2 rstb = 1'b1;
    #1;
    cnt = 0;
    while (busy_o[0] && cnt < 100) begin
      cnt++;
      set_wr(0, 2, 64'h12345678, 8'hF); set_rd1(0, 2); set_rd0(1, 0); set_rd1(1, 1);
      cyc();
    end
    chk("reinit cycles", 0, 64'(cnt), 64'd16);
    set_rd0(0, 2); set_rd1(2, 1); cyc(); cyc();
    chk("ignored write", 0, dout0_o[0], 64'hDEADBEEF);
    chk("committed write", 2, dout1_o[2], 64'h5555AAAA5555AAAA);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
